// File: rtl/uart_echo_tester_if.sv
// Status and serial-line bundle for uart_echo_tester; master is the tester, slave is whoever starts it.
// Pure wiring: no latency, no backpressure (start is a single-cycle pulse).
interface uart_echo_tester_if;
  logic       start_in;
  logic       uart_rx_serial_in;
  logic       uart_tx_serial_out;
  logic       busy_out;
  logic       done_out;
  logic       pass_out;
  logic [7:0] err_count_out;
  logic [7:0] rx_count_out;

  modport master (
    input  start_in, uart_rx_serial_in,
    output uart_tx_serial_out, busy_out, done_out, pass_out, err_count_out, rx_count_out
  );

  modport slave (
    output start_in, uart_rx_serial_in,
    input  uart_tx_serial_out, busy_out, done_out, pass_out, err_count_out, rx_count_out
  );
endinterface

// File: rtl/uart_echo_tester.sv
// UART initiator: sends N_BYTES LFSR bytes back-to-back and checks the echoed stream against its own LFSR copy.
// TX line low one cycle after the start is accepted; start is ignored while a run is busy, no other backpressure.
module uart_echo_tester #(
  parameter int         CLK_FREQUENCY = 100_000_000,
  parameter int         BAUD_RATE     = 115_200,
  parameter int         N_BYTES       = 32,
  parameter logic [7:0] SEED          = 8'hA5,
  parameter int         TIMEOUT_BITS  = 200
) (
  input  logic               sysclk,
  input  logic               rst_in,
  uart_echo_tester_if.master bus
);

  localparam int CPB     = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF    = CPB / 2;
  localparam int TO_CLKS = TIMEOUT_BITS * CPB;
  localparam int CW      = $clog2(CPB + 1);
  localparam int TW      = $clog2(TO_CLKS + 1);

  localparam logic [7:0]    N8      = 8'(N_BYTES);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CLKS - 1);

  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [9:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bitn;
  logic          r_tx_busy;
  logic [7:0]    r_tx_bytes;
  logic [7:0]    r_tx_lfsr;

  logic [1:0]    r_rx_sync;
  logic          r_rx_prev;
  logic          r_rx_on;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bitn;
  logic [7:0]    r_rx_data;
  logic [7:0]    r_rx_lfsr;
  logic [7:0]    r_rx_count;
  logic [7:0]    r_err;
  logic          r_pass;
  logic [TW-1:0] r_to_cnt;

  logic          w_active, w_start;
  logic          w_tx_bit_end, w_tx_frame_end, w_tx_last;
  logic          w_rx_d, w_rx_fall, w_rx_smp, w_rx_byte, w_rx_bad, w_rx_hit, w_timeout;
  logic [7:0]    w_rxc_nxt, w_err_nxt;
  logic [8:0]    w_sum;

  assign w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_start        = bus.start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_tx_bit_end   = r_tx_busy && (r_tx_cnt == CPB_M1);
  assign w_tx_frame_end = w_tx_bit_end && (r_tx_bitn == 4'd9);
  assign w_tx_last      = w_tx_frame_end && ((r_tx_bytes + 8'd1) == N8);

  assign w_rx_d    = r_rx_sync[1];
  assign w_rx_fall = r_rx_prev && !w_rx_d;
  assign w_rx_smp  = r_rx_on && ((r_rx_bitn == 4'd0) ? (r_rx_cnt == HALF_M1) : (r_rx_cnt == CPB_M1));
  assign w_rx_byte = w_rx_smp && (r_rx_bitn == 4'd9) && w_active;
  assign w_rx_bad  = (r_rx_data != r_rx_lfsr) || !w_rx_d;
  assign w_rx_hit  = w_rx_byte && ((r_rx_count + 8'd1) == N8);
  assign w_timeout = (r_state == S_DRAIN) && (r_to_cnt == TO_M1) && !w_rx_byte;

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rxc_nxt   = r_rx_count;
    w_err_nxt   = r_err;
    w_sum       = {1'b0, r_err} + {1'b0, N8 - r_rx_count};
    case (r_state)
      S_IDLE:  if (bus.start_in) w_state_nxt = S_RUN;
      S_RUN:   if (w_rx_hit) w_state_nxt = S_DONE;
               else if (w_tx_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rx_hit || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  if (bus.start_in) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_rx_byte) begin
      w_rxc_nxt = r_rx_count + 8'd1;
      if (w_rx_bad && (r_err != 8'hFF)) w_err_nxt = r_err + 8'd1;
    end else if (w_timeout) begin
      // bytes never echoed count as errors, saturating at 255
      w_err_nxt = w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_bytes <= '0;
      r_tx_lfsr  <= SEED;
    end else if (w_start) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_bytes <= '0;
      r_tx_lfsr  <= SEED;
    end else if (r_state != S_RUN) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_busy  <= 1'b0;
    end else if (!r_tx_busy) begin
      if (r_tx_bytes != N8) begin
        r_tx_shift <= {1'b1, r_tx_lfsr, 1'b0};
        r_tx_lfsr  <= lfsr_next(r_tx_lfsr);
        r_tx_busy  <= 1'b1;
        r_tx_bitn  <= '0;
        r_tx_cnt   <= '0;
      end
    end else if (w_tx_bit_end) begin
      r_tx_cnt <= '0;
      if (w_tx_frame_end) begin
        r_tx_bytes <= r_tx_bytes + 8'd1;
        r_tx_bitn  <= '0;
        // next start bit follows the stop bit with no idle gap
        if (!w_tx_last) begin
          r_tx_shift <= {1'b1, r_tx_lfsr, 1'b0};
          r_tx_lfsr  <= lfsr_next(r_tx_lfsr);
        end else begin
          r_tx_shift <= '1;
          r_tx_busy  <= 1'b0;
        end
      end else begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_bitn  <= r_tx_bitn + 4'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + CW'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], bus.uart_rx_serial_in};
      r_rx_prev <= r_rx_sync[1];
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      r_rx_on   <= 1'b0;
      r_rx_cnt  <= '0;
      r_rx_bitn <= '0;
      r_rx_data <= '0;
    end else if (!w_active) begin
      r_rx_on <= 1'b0;
    end else if (!r_rx_on) begin
      if (w_rx_fall) begin
        r_rx_on   <= 1'b1;
        r_rx_cnt  <= '0;
        r_rx_bitn <= '0;
      end
    end else if (w_rx_smp) begin
      r_rx_cnt <= '0;
      case (r_rx_bitn)
        // a start bit that is high again at mid-bit was a glitch
        4'd0:    if (w_rx_d) r_rx_on <= 1'b0;
                 else r_rx_bitn <= 4'd1;
        4'd9:    r_rx_on <= 1'b0;
        default: begin
          r_rx_data <= {w_rx_d, r_rx_data[7:1]};
          r_rx_bitn <= r_rx_bitn + 4'd1;
        end
      endcase
    end else begin
      r_rx_cnt <= r_rx_cnt + CW'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst_in) begin
    if (rst_in) begin
      r_rx_count <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
      r_rx_lfsr  <= SEED;
      r_to_cnt   <= '0;
    end else if (w_start) begin
      r_rx_count <= '0;
      r_err      <= '0;
      r_pass     <= 1'b0;
      r_rx_lfsr  <= SEED;
      r_to_cnt   <= '0;
    end else begin
      r_rx_count <= w_rxc_nxt;
      r_err      <= w_err_nxt;
      if (w_rx_byte) r_rx_lfsr <= lfsr_next(r_rx_lfsr);
      if (w_rx_byte || ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN))) r_to_cnt <= '0;
      else if (r_state == S_DRAIN) r_to_cnt <= r_to_cnt + TW'(1);
      if ((w_state_nxt == S_DONE) && (r_state != S_DONE))
        r_pass <= (w_err_nxt == 8'd0) && (w_rxc_nxt == N8);
    end
  end

  assign bus.uart_tx_serial_out = r_tx_shift[0];
  assign bus.busy_out           = w_active;
  assign bus.done_out           = (r_state == S_DONE);
  assign bus.pass_out           = r_pass;
  assign bus.err_count_out      = r_err;
  assign bus.rx_count_out       = r_rx_count;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Randomized bench for uart_echo_tester: line-fault injection between TX and RX, scoreboarded results.
module tb_uart_echo_tester;
  localparam int         CLK_HZ = 1_600_000;
  localparam int         BAUD   = 100_000;
  localparam int         CPB    = 16;
  localparam int         NB     = 4;
  localparam int         TOB    = 20;
  localparam logic [7:0] SEED   = 8'hA5;

  // line modes: 0 loopback, 1 bit3 of byte1 inverted, 2 stop bit of byte0 low, 3 silent (bench-driven line)
  typedef struct {int rxc; int err; int pass; int min_d; int max_d;} res_t;

  logic sysclk = 1'b0;
  logic rst_in = 1'b1;
  uart_echo_tester_if bus();

  uart_echo_tester #(
    .CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .N_BYTES(NB), .SEED(SEED), .TIMEOUT_BITS(TOB)
  ) dut (
    .sysclk(sysclk),
    .rst_in(rst_in),
    .bus(bus)
  );

  always #5 sysclk = ~sysclk;

  res_t       res_q[$];
  logic [7:0] txq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         mode = 0;
  logic       fake_line = 1'b1;
  logic       in_frame = 1'b0;
  int         fcnt = 0;
  int         fbyte = 0;
  logic [7:0] fdat = 8'h00;
  logic       done_q = 1'b0;
  logic       corrupt;

  assign corrupt = in_frame &&
                   (((mode == 1) && (fbyte == 1) && (fcnt / CPB == 4)) ||
                    ((mode == 2) && (fbyte == 0) && (fcnt >= 9 * CPB) && (fcnt < 9 * CPB + (3 * CPB) / 4)));
  assign bus.uart_rx_serial_in = (mode == 3) ? fake_line : (bus.uart_tx_serial_out ^ corrupt);

  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] ref_next(input logic [7:0] v);
    logic [7:0] taps;
    taps = v & 8'hB8;
    return {v[6:0], ^taps};
  endfunction

  function automatic res_t model(input int m);
    res_t r;
    r.rxc   = (m == 3) ? 0 : NB;
    r.err   = (m == 0) ? 0 : ((m == 3) ? NB : 1);
    r.pass  = (m == 0) ? 1 : 0;
    // cycle distance from start request to DONE, counted between negedges
    if (m == 3) begin
      r.min_d = 2 + 10 * NB * CPB + TOB * CPB - 1;
      r.max_d = 2 + 10 * NB * CPB + TOB * CPB + 1;
    end else begin
      r.min_d = 2 + (10 * NB - 1) * CPB;
      r.max_d = 2 + 10 * NB * CPB + 10 * CPB;
    end
    return r;
  endfunction

  // TX frame decoder and result monitor
  always @(negedge sysclk) begin
    if (rst_in) begin
      in_frame = 1'b0;
      done_q   = 1'b0;
      fbyte    = 0;
    end else begin
      if (!in_frame) begin
        if (!bus.busy_out) fbyte = 0;
        if (bus.uart_tx_serial_out == 1'b0) begin
          in_frame = 1'b1;
          fcnt     = 0;
        end
      end else begin
        fcnt++;
        if ((fcnt % CPB == CPB / 2) && (fcnt / CPB >= 1) && (fcnt / CPB <= 8))
          fdat = {bus.uart_tx_serial_out, fdat[7:1]};
        if (fcnt == 9 * CPB + CPB / 2) begin
          chk("tx_stop_bit", int'(bus.uart_tx_serial_out), 1);
          if (txq.size() == 0) chk("tx_unexpected_byte", int'(fdat), -1);
          else chk("tx_byte", int'(fdat), int'(txq.pop_front()));
        end
        if (fcnt == 10 * CPB) begin
          fbyte++;
          if (bus.uart_tx_serial_out == 1'b0) fcnt = 0;
          else in_frame = 1'b0;
        end
      end
      if (bus.done_out && !done_q) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", int'(bus.rx_count_out), -1);
        end else begin
          res_t r;
          int d;
          r = res_q.pop_front();
          d = cyc - start_cyc;
          chk("rx_count", int'(bus.rx_count_out), r.rxc);
          chk("err_count", int'(bus.err_count_out), r.err);
          chk("pass", int'(bus.pass_out), r.pass);
          chk("busy_at_done", int'(bus.busy_out), 0);
          checks++;
          if (d < r.min_d || d > r.max_d) begin
            errors++;
            $display("FAIL done_latency actual=%0d required=%0d..%0d", d, r.min_d, r.max_d);
          end
        end
      end
      done_q = bus.done_out;
    end
  end

  task automatic do_start(input int m);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < NB; i++) begin
      txq.push_back(v);
      v = ref_next(v);
    end
    res_q.push_back(model(m));
    @(negedge sysclk);
    bus.start_in = 1'b1;
    start_cyc = cyc;
    @(posedge sysclk);
    #1;
    bus.start_in = 1'b0;
    chk("start_busy", int'(bus.busy_out), 1);
    chk("start_done", int'(bus.done_out), 0);
    chk("start_tx_idle", int'(bus.uart_tx_serial_out), 1);
    chk("start_rx_cleared", int'(bus.rx_count_out), 0);
    @(posedge sysclk);
    #1;
    chk("first_start_bit", int'(bus.uart_tx_serial_out), 0);
    @(negedge sysclk);
  endtask

  task automatic send_fake(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      fake_line = (i == 0) ? 1'b0 : ((i == 9) ? 1'b1 : b[i-1]);
      repeat (CPB) @(negedge sysclk);
    end
    fake_line = 1'b1;
  endtask

  task automatic run(input int m);
    res_t r;
    bit   extra;
    int   extra_t, g_t, t;
    r = model(m);
    mode = m;
    fake_line = 1'b1;
    repeat ($urandom_range(1, 40)) @(negedge sysclk);
    do_start(m);
    extra   = 1'($urandom_range(0, 1));
    extra_t = $urandom_range(20, 10 * NB * CPB - 40);
    g_t     = $urandom_range(5, 10 * NB * CPB - 20);
    t = 0;
    while (t < 4000 && !bus.done_out) begin
      bus.start_in = extra && (t == extra_t);
      if (m == 3) fake_line = !(t >= g_t && t < g_t + 5);
      @(negedge sysclk);
      t++;
    end
    bus.start_in = 1'b0;
    fake_line = 1'b1;
    if (!bus.done_out) chk("done_reached", 0, 1);
    repeat (3) @(negedge sysclk);
    // a well-formed frame arriving in DONE must be ignored
    mode = 3;
    send_fake(8'($urandom_range(0, 255)));
    repeat (20) @(negedge sysclk);
    chk("done_hold", int'(bus.done_out), 1);
    chk("done_rx_frozen", int'(bus.rx_count_out), r.rxc);
    chk("done_err_frozen", int'(bus.err_count_out), r.err);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation timed out");
  end

  initial begin
    int m;
    bus.start_in = 1'b0;
    rst_in = 1'b1;
    repeat (3) @(negedge sysclk);
    chk("rst_tx", int'(bus.uart_tx_serial_out), 1);
    chk("rst_busy", int'(bus.busy_out), 0);
    chk("rst_done", int'(bus.done_out), 0);
    chk("rst_pass", int'(bus.pass_out), 0);
    chk("rst_err", int'(bus.err_count_out), 0);
    chk("rst_rxc", int'(bus.rx_count_out), 0);
    rst_in = 1'b0;
    repeat (5) @(negedge sysclk);

    for (int r = 0; r < 8; r++) begin
      m = (r < 4) ? r : $urandom_range(0, 3);
      run(m);
    end

    // reset in the middle of byte 1, then a clean run
    mode = 0;
    do_start(0);
    for (int t = 0; t < 2000 && !(fbyte == 1 && fcnt >= 50); t++) @(negedge sysclk);
    if (!(fbyte == 1 && fcnt >= 50)) chk("reach_byte1", fbyte, 1);
    #3;
    rst_in = 1'b1;
    #1;
    chk("midrst_tx", int'(bus.uart_tx_serial_out), 1);
    chk("midrst_busy", int'(bus.busy_out), 0);
    chk("midrst_done", int'(bus.done_out), 0);
    chk("midrst_rxc", int'(bus.rx_count_out), 0);
    chk("midrst_err", int'(bus.err_count_out), 0);
    txq.delete();
    res_q.delete();
    repeat (3) @(negedge sysclk);
    rst_in = 1'b0;
    run(0);

    chk("tx_queue_drained", txq.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
